// File: rtl/lab3_g29_p3_mux_arbiter.sv
// lab3_g29_p3_mux_arbiter: 8-requester round-robin arbiter driving an 8:1
// 4-bit data mux. A grant lasts until the grantee drops its request or
// HOLD_MAX words have been accepted, then one IDLE bubble precedes the next grant.
module lab3_g29_p3_mux_arbiter #(
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic [3:0] in0,
    input  logic [3:0] in1,
    input  logic [3:0] in2,
    input  logic [3:0] in3,
    input  logic [3:0] in4,
    input  logic [3:0] in5,
    input  logic [3:0] in6,
    input  logic [3:0] in7,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [3:0] out_data,
    output logic [2:0] sel,
    output logic [7:0] gnt,
    output logic [7:0] xfer_cnt
);

    localparam int unsigned N_REQ  = 8;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned BEAT_W = 4;
    localparam int unsigned DATA_W = 4;

    localparam logic [BEAT_W-1:0] HOLD_LIMIT = BEAT_W'(HOLD_MAX);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    state_t              state, state_n;
    logic [IDX_W-1:0]    ptr, ptr_n;
    logic [IDX_W-1:0]    sel_n;
    logic [N_REQ-1:0]    gnt_n;
    logic [BEAT_W-1:0]   beat, beat_n;
    logic [7:0]          xfer_cnt_n;

    logic                found;
    logic [IDX_W-1:0]    pick;
    logic [IDX_W-1:0]    idx;
    logic                xfer;
    logic                last_beat;
    logic [DATA_W-1:0]   mux_data;

    // Round-robin search: first set request at or above ptr, wrapping 7->0.
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        idx   = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            idx = IDX_W'(ptr + IDX_W'(i));
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // 8:1 data select driven by the registered grant index.
    always_comb begin
        mux_data = '0;
        case (sel)
            3'd0: mux_data = in0;
            3'd1: mux_data = in1;
            3'd2: mux_data = in2;
            3'd3: mux_data = in3;
            3'd4: mux_data = in4;
            3'd5: mux_data = in5;
            3'd6: mux_data = in6;
            3'd7: mux_data = in7;
            default: mux_data = '0;
        endcase
    end

    // Valid follows the grantee's live request; data forced to zero when not valid.
    assign out_valid = (state == SERVE) && req[sel];
    assign out_data  = out_valid ? mux_data : '0;
    assign xfer      = out_valid && out_ready;
    assign last_beat = (BEAT_W'(beat + BEAT_W'(1)) == HOLD_LIMIT);

    // Next-state and register-update logic for the arbiter FSM.
    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        sel_n      = sel;
        gnt_n      = gnt;
        beat_n     = beat;
        xfer_cnt_n = xfer_cnt;
        case (state)
            IDLE: begin
                if (found) begin
                    sel_n   = pick;
                    gnt_n   = N_REQ'(8'd1 << pick);
                    state_n = SERVE;
                end
            end
            SERVE: begin
                if (!req[sel]) begin
                    state_n = IDLE;
                    ptr_n   = IDX_W'(sel + IDX_W'(1));
                    beat_n  = '0;
                    gnt_n   = '0;
                end else if (xfer) begin
                    xfer_cnt_n = 8'(xfer_cnt + 8'd1);
                    if (last_beat) begin
                        state_n = IDLE;
                        ptr_n   = IDX_W'(sel + IDX_W'(1));
                        beat_n  = '0;
                        gnt_n   = '0;
                    end else begin
                        beat_n = BEAT_W'(beat + BEAT_W'(1));
                    end
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
                beat_n  = '0;
            end
        endcase
    end

    // State register; reset aborts any grant and clears all counts immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            sel      <= '0;
            gnt      <= '0;
            beat     <= '0;
            xfer_cnt <= '0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            sel      <= sel_n;
            gnt      <= gnt_n;
            beat     <= beat_n;
            xfer_cnt <= xfer_cnt_n;
        end
    end

endmodule

// File: tb/tb_lab3_g29_p3_mux_arbiter.sv
// Directed bench for lab3_g29_p3_mux_arbiter with HOLD_MAX=4.
// Inputs change 1ns after the rising edge; outputs are checked 1-2ns after it.
`timescale 1ns/1ps
module tb_lab3_g29_p3_mux_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [3:0] din [8];
    logic       out_ready;
    logic       out_valid;
    logic [3:0] out_data;
    logic [2:0] sel;
    logic [7:0] gnt;
    logic [7:0] xfer_cnt;

    int total = 0;
    int bad   = 0;

    lab3_g29_p3_mux_arbiter #(.HOLD_MAX(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .in0       (din[0]),
        .in1       (din[1]),
        .in2       (din[2]),
        .in3       (din[3]),
        .in4       (din[4]),
        .in5       (din[5]),
        .in6       (din[6]),
        .in7       (din[7]),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .sel       (sel),
        .gnt       (gnt),
        .xfer_cnt  (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req       = 8'h00;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) din[i] = 4'(i + 1);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req       = 8'hFF;
        out_ready = 1'b1;
        #2;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 4'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", out_data); end
        total++; if (gnt !== 8'h00) begin bad++; $display("FAIL reset_gnt got=%h exp=00", gnt); end
        total++; if (sel !== 3'd0) begin bad++; $display("FAIL reset_sel got=%0d exp=0", sel); end
        total++; if (xfer_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", xfer_cnt); end
        tick();
        total++; if (gnt !== 8'h00) begin bad++; $display("FAIL reset_held_gnt got=%h exp=00", gnt); end
    endtask

    task automatic test_single();
        do_reset();
        din[2]    = 4'hA;
        req       = 8'h04;
        out_ready = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_idle_valid got=%b exp=0", out_valid); end
        tick();
        for (int b = 0; b < 4; b++) begin
            total++; if (sel !== 3'd2) begin bad++; $display("FAIL single_sel beat=%0d got=%0d exp=2", b, sel); end
            total++; if (gnt !== 8'h04) begin bad++; $display("FAIL single_gnt beat=%0d got=%h exp=04", b, gnt); end
            total++; if (out_valid !== 1'b1 || out_data !== 4'hA) begin bad++; $display("FAIL single_data beat=%0d got=%b/%h exp=1/a", b, out_valid, out_data); end
            tick();
        end
        total++; if (out_valid !== 1'b0 || gnt !== 8'h00) begin bad++; $display("FAIL single_bubble got=%b/%h exp=0/00", out_valid, gnt); end
        total++; if (xfer_cnt !== 8'd4) begin bad++; $display("FAIL single_cnt got=%0d exp=4", xfer_cnt); end
        tick();
        total++; if (sel !== 3'd2 || gnt !== 8'h04 || out_valid !== 1'b1) begin bad++; $display("FAIL single_regrant got=%0d/%h/%b exp=2/04/1", sel, gnt, out_valid); end
    endtask

    task automatic test_round_robin();
        logic [7:0] eg;
        do_reset();
        req       = 8'hFF;
        out_ready = 1'b1;
        for (int g = 0; g < 9; g++) begin
            tick();
            eg = 8'h01 << (g % 8);
            total++; if (sel !== 3'(g % 8) || gnt !== eg) begin bad++; $display("FAIL rr_grant g=%0d got=%0d/%h exp=%0d/%h", g, sel, gnt, g % 8, eg); end
            for (int b = 0; b < 4; b++) begin
                total++; if (out_valid !== 1'b1 || out_data !== 4'((g % 8) + 1)) begin bad++; $display("FAIL rr_data g=%0d b=%0d got=%b/%h exp=1/%h", g, b, out_valid, out_data, (g % 8) + 1); end
                tick();
            end
            total++; if (out_valid !== 1'b0 || gnt !== 8'h00) begin bad++; $display("FAIL rr_bubble g=%0d got=%b/%h exp=0/00", g, out_valid, gnt); end
        end
        total++; if (xfer_cnt !== 8'd36) begin bad++; $display("FAIL rr_cnt got=%0d exp=36", xfer_cnt); end
    endtask

    task automatic test_wrap();
        logic [2:0] exp_sel [3];
        exp_sel[0] = 3'd7; exp_sel[1] = 3'd0; exp_sel[2] = 3'd7;
        do_reset();
        req       = 8'h40;
        out_ready = 1'b1;
        tick();
        total++; if (sel !== 3'd6) begin bad++; $display("FAIL wrap_pre got=%0d exp=6", sel); end
        for (int b = 0; b < 4; b++) tick();
        req = 8'h81;
        for (int g = 0; g < 3; g++) begin
            tick();
            total++; if (sel !== exp_sel[g] || gnt !== (8'h01 << exp_sel[g])) begin bad++; $display("FAIL wrap_grant g=%0d got=%0d/%h exp=%0d", g, sel, gnt, exp_sel[g]); end
            for (int b = 0; b < 4; b++) tick();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        din[3]    = 4'h5;
        req       = 8'h08;
        out_ready = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            total++; if (out_valid !== 1'b1 || out_data !== 4'h5 || gnt !== 8'h08) begin bad++; $display("FAIL bp_hold c=%0d got=%b/%h/%h exp=1/5/08", c, out_valid, out_data, gnt); end
            total++; if (xfer_cnt !== 8'd0) begin bad++; $display("FAIL bp_cnt c=%0d got=%0d exp=0", c, xfer_cnt); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        for (int b = 0; b < 4; b++) begin
            total++; if (out_valid !== 1'b1 || xfer_cnt !== 8'(b)) begin bad++; $display("FAIL bp_resume b=%0d got=%b/%0d exp=1/%0d", b, out_valid, xfer_cnt, b); end
            tick();
        end
        total++; if (out_valid !== 1'b0 || xfer_cnt !== 8'd4) begin bad++; $display("FAIL bp_end got=%b/%0d exp=0/4", out_valid, xfer_cnt); end
    endtask

    task automatic test_early_drop();
        do_reset();
        din[5]    = 4'hC;
        req       = 8'h20;
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        req = 8'h41;
        #1;
        total++; if (out_valid !== 1'b0 || out_data !== 4'h0) begin bad++; $display("FAIL drop_valid got=%b/%h exp=0/0", out_valid, out_data); end
        total++; if (gnt !== 8'h20 || xfer_cnt !== 8'd2) begin bad++; $display("FAIL drop_state got=%h/%0d exp=20/2", gnt, xfer_cnt); end
        tick();
        total++; if (gnt !== 8'h00 || out_valid !== 1'b0 || xfer_cnt !== 8'd2) begin bad++; $display("FAIL drop_idle got=%h/%b/%0d exp=00/0/2", gnt, out_valid, xfer_cnt); end
        tick();
        total++; if (sel !== 3'd6 || gnt !== 8'h40) begin bad++; $display("FAIL drop_ptr got=%0d/%h exp=6/40", sel, gnt); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req       = 8'h10;
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        total++; if (gnt !== 8'h10 || xfer_cnt !== 8'd2) begin bad++; $display("FAIL rmid_pre got=%h/%0d exp=10/2", gnt, xfer_cnt); end
        #1;
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || gnt !== 8'h00 || xfer_cnt !== 8'd0 || sel !== 3'd0) begin bad++; $display("FAIL rmid_async got=%b/%h/%0d/%0d exp=0/00/0/0", out_valid, gnt, xfer_cnt, sel); end
        req = 8'h30;
        tick();
        rst_n = 1'b1;
        tick();
        total++; if (sel !== 3'd4 || gnt !== 8'h10) begin bad++; $display("FAIL rmid_regrant got=%0d/%h exp=4/10", sel, gnt); end
    endtask

    task automatic test_cnt_wrap();
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        do_reset();
        req       = 8'hFF;
        out_ready = 1'b1;
        #1;
        for (int c = 0; c < 400 && !done; c++) begin
            if (out_valid === 1'b1) n++;
            tick();
            if (n == 255) begin
                total++; if (xfer_cnt !== 8'd255) begin bad++; $display("FAIL cnt_255 got=%0d exp=255", xfer_cnt); end
            end
            if (n == 256) done = 1'b1;
        end
        total++; if (!done) begin bad++; $display("FAIL cnt_timeout got=%0d exp=256", n); end
        total++; if (xfer_cnt !== 8'd0) begin bad++; $display("FAIL cnt_wrap got=%0d exp=0", xfer_cnt); end
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = 8'h00;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) din[i] = 4'h0;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_backpressure();
        test_early_drop();
        test_reset_mid();
        test_cnt_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lab3_g29_p3_mux_arbiter.md
LAB3_G29_P3_MUX_ARBITER -- requirements
Module: lab3_g29_p3_mux_arbiter

Interface
REQ-001 Parameter: HOLD_MAX, default 4, maximum accepted beats per grant; legal range 1..15.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: req  input  8  per-requester request; bit i belongs to in_i.
REQ-006 Port: in0..in7  input  4 each  requester data words.
REQ-007 Port: out_ready  input  1  consumer accepts the current word.
REQ-008 Port: out_valid  output  1  out_data is a valid word.
REQ-009 Port: out_data  output  4  selected word; 4'h0 when out_valid=0.
REQ-010 Port: sel  output  3  registered index of the current grantee, also the 8:1 data select.
REQ-011 Port: gnt  output  8  one-hot grant; all zero in IDLE.
REQ-012 Port: xfer_cnt  output  8  total accepted words, modulo 256.

Function
REQ-013 The FSM SHALL have two states: IDLE and SERVE.
REQ-014 In IDLE with req!=0, the block SHALL pick the first set req bit searching upward from ptr with 7->0 wrap, and SHALL load sel/gnt and enter SERVE at the next edge.
REQ-015 In IDLE with req==0, all registers SHALL hold.
REQ-016 In SERVE, out_valid SHALL equal req[sel] combinationally, and out_data SHALL equal in[sel] while out_valid=1.
REQ-017 A transfer SHALL occur on an edge where out_valid=1 and out_ready=1; each transfer increments beat and xfer_cnt (xfer_cnt 255->0 wrap).
REQ-018 With out_ready=0, sel, gnt and beat SHALL hold with no timeout.
REQ-019 SERVE SHALL exit to IDLE at the edge where req[sel]=0, or a transfer brings beat to HOLD_MAX.
REQ-020 On SERVE exit, ptr SHALL load sel+1 mod 8, beat SHALL clear, and gnt SHALL clear.
REQ-021 Every grant SHALL be followed by exactly one IDLE cycle, so there is a one-cycle bubble between grants.
REQ-022 Latency: a req rising before edge k with the block idle SHALL give out_valid=1 in the cycle after edge k.
REQ-023 gnt SHALL be one-hot and consistent with sel in SERVE.
REQ-024 Requests from non-granted requesters SHALL NOT affect sel until the next IDLE.

Reset
REQ-025 With rst_n=0, the block SHALL immediately set state=IDLE, ptr=0, sel=0, gnt=0, beat=0, xfer_cnt=0, out_valid=0 and out_data=0.
REQ-026 Reset asserted mid-SERVE SHALL abort the grant, with no partial count retained.
REQ-027 After reset release, arbitration SHALL begin at ptr=0.

Verification
REQ-028 Single requester: req=8'h04, in2=4'hA, out_ready=1, HOLD_MAX=4 -> sel=2, gnt=8'h04, 4 beats of 4'hA, 1 IDLE cycle, then re-grant to 2; xfer_cnt=4 after the first grant.
REQ-029 Round-robin: req=8'hFF continuous, out_ready=1 -> grant order 0,1,...,7,0 with 4 beats each, and an IDLE bubble between each grant.
REQ-030 Wrap: ptr=7, req=8'h81 -> grant 7, then grant 0, then grant 7.
REQ-031 Backpressure: grant 3, out_ready=0 for 5 cycles -> out_valid=1, out_data=in3, beat=0 held; resumes counting when out_ready=1.
REQ-032 Early drop: grant 5, req[5] falls after 2 beats -> out_valid=0 that cycle, IDLE next, ptr=6, xfer_cnt +2.
REQ-033 Reset mid-SERVE: rst_n low during grant 4 -> out_valid=0, gnt=0 and xfer_cnt=0 without waiting for clk; after release with req=8'h30, the next grant is 4.
